// File: rtl/dcache_refill.sv
// Data-cache miss handler: optional dirty-victim write-back, then word-by-word line fill.
// Define DCACHE_WB_EN for the write-back build; leave it undefined for write-through (fill only).
module dcache_refill #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_miss,
    input  logic [ADDR_W-1:0]          i_miss_addr,
    input  logic                       i_evict_valid,
    input  logic [ADDR_W-1:0]          i_evict_addr,
    input  logic [32*LINE_WORDS-1:0]   i_evict_data,
    output logic [32*LINE_WORDS-1:0]   o_line,
    output logic                       o_done,
    output logic                       o_busy,
    output logic                       o_mem_req,
    output logic                       o_mem_we,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic [31:0]                o_mem_wdata,
    input  logic                       i_mem_ack,
    input  logic [31:0]                i_mem_rdata
);

    localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
    localparam int unsigned OFF_W  = CNT_W + 2;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [LINE_W-1:0]   miss_line;
    logic [31:0]         line_words [LINE_WORDS];
    logic                unused_bits;

`ifdef DCACHE_WB_EN
    logic [LINE_W-1:0]   evict_line;
    logic [31:0]         evict_words [LINE_WORDS];

    assign unused_bits = ^{i_miss_addr[OFF_W-1:0], i_evict_addr[OFF_W-1:0]};
`else
    // Write-through build never writes memory; evict inputs are sunk.
    assign o_mem_we    = 1'b0;
    assign o_mem_wdata = '0;
    assign unused_bits = ^{i_miss_addr[OFF_W-1:0], i_evict_valid, i_evict_addr, i_evict_data};
`endif

    // State register plus latched miss context and the refilled line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            miss_line <= '0;
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                line_words[k] <= '0;
            end
`ifdef DCACHE_WB_EN
            evict_line <= '0;
            for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                evict_words[k] <= '0;
            end
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && i_miss) begin
                miss_line <= i_miss_addr[ADDR_W-1:OFF_W];
`ifdef DCACHE_WB_EN
                evict_line <= i_evict_addr[ADDR_W-1:OFF_W];
                for (int unsigned k = 0; k < LINE_WORDS; k++) begin
                    evict_words[k] <= i_evict_data[32*k +: 32];
                end
`endif
            end
            if (state == FILL && i_mem_ack) begin
                line_words[cnt] <= i_mem_rdata;
            end
        end
    end

    // Next-state, word counter and memory port decode.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        o_mem_req  = 1'b0;
        o_mem_addr = '0;
`ifdef DCACHE_WB_EN
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
`endif
        case (state)
            IDLE: begin
                if (i_miss) begin
                    cnt_nxt = '0;
`ifdef DCACHE_WB_EN
                    state_nxt = i_evict_valid ? EVICT : FILL;
`else
                    state_nxt = FILL;
`endif
                end
            end
`ifdef DCACHE_WB_EN
            EVICT: begin
                o_mem_req   = 1'b1;
                o_mem_we    = 1'b1;
                o_mem_addr  = {evict_line, cnt, 2'b00};
                o_mem_wdata = evict_words[cnt];
                if (i_mem_ack) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = FILL;
                    end
                end
            end
`endif
            FILL: begin
                o_mem_req  = 1'b1;
                o_mem_addr = {miss_line, cnt, 2'b00};
                if (i_mem_ack) begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign o_done = (state == DONE);
    assign o_busy = (state != IDLE);

    for (genvar k = 0; k < LINE_WORDS; k++) begin : g_pack
        assign o_line[32*k +: 32] = line_words[k];
    end

endmodule

// File: tb/tb_dcache_refill.sv
// Directed bench for dcache_refill: scoreboard of expected memory requests and refilled lines.
// Works for both builds; DCACHE_WB_EN selects whether dirty misses expect write-back traffic.
module tb_dcache_refill;

    localparam int unsigned LW = 16;
`ifdef DCACHE_WB_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic                clk;
    logic                rst;
    logic                i_miss;
    logic [31:0]         i_miss_addr;
    logic                i_evict_valid;
    logic [31:0]         i_evict_addr;
    logic [32*LW-1:0]    i_evict_data;
    logic [32*LW-1:0]    o_line;
    logic                o_done;
    logic                o_busy;
    logic                o_mem_req;
    logic                o_mem_we;
    logic [31:0]         o_mem_addr;
    logic [31:0]         o_mem_wdata;
    logic                i_mem_ack;
    logic [31:0]         i_mem_rdata;

    req_t                req_q [$];
    logic [32*LW-1:0]    line_q [$];
    logic [32*LW-1:0]    last_line;
    int                  checks;
    int                  fails;

    dcache_refill #(
        .LINE_WORDS(LW),
        .ADDR_W    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss       (i_miss),
        .i_miss_addr  (i_miss_addr),
        .i_evict_valid(i_evict_valid),
        .i_evict_addr (i_evict_addr),
        .i_evict_data (i_evict_data),
        .o_line       (o_line),
        .o_done       (o_done),
        .o_busy       (o_busy),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32*LW-1:0] obs, input logic [32*LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a miss in an IDLE cycle and push the expected traffic and line.
    task automatic start_miss(input logic [31:0] maddr, input bit ev, input logic [31:0] eaddr,
                              input logic [31:0] ebase, input logic [31:0] rbase);
        logic [32*LW-1:0] line;
        req_t e;
        @(negedge clk);
        chk("line_hold", o_line, last_line);
        chk("idle_busy", o_busy, 1'b0);
        i_miss        = 1'b1;
        i_miss_addr   = maddr;
        i_evict_valid = ev;
        i_evict_addr  = eaddr;
        for (int k = 0; k < LW; k++) begin
            i_evict_data[32*k +: 32] = ebase + 32'(k);
        end
        if (WB && ev) begin
            for (int k = 0; k < LW; k++) begin
                e.we = 1'b1; e.addr = (eaddr & ~32'h3F) + 32'(4*k); e.data = ebase + 32'(k);
                req_q.push_back(e);
            end
        end
        for (int k = 0; k < LW; k++) begin
            e.we = 1'b0; e.addr = (maddr & ~32'h3F) + 32'(4*k); e.data = rbase + 32'(k);
            req_q.push_back(e);
            line[32*k +: 32] = rbase + 32'(k);
        end
        line_q.push_back(line);
        last_line = line;
        @(posedge clk);
    endtask

    // Act as memory (ack every 'period' request cycles) until o_done, checking every step.
    task automatic service(input int period, input int stray_cyc, input bit miss_at_done);
        int          cyc;
        int          phase;
        int          exp_done;
        bit          done_seen;
        bit          have_prev;
        logic        prev_we;
        logic [31:0] prev_addr;
        logic [31:0] prev_wdata;
        req_t        e;
        exp_done  = 1 + period * req_q.size();
        cyc       = 0;
        phase     = 0;
        done_seen = 1'b0;
        have_prev = 1'b0;
        while (!done_seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            i_miss      = 1'b0;
            i_mem_ack   = 1'b0;
            i_mem_rdata = $urandom;
            if (cyc == stray_cyc) begin
                i_miss        = 1'b1;
                i_miss_addr   = 32'hFFFF_0F00;
                i_evict_valid = ~i_evict_valid;
            end
            if (cyc == 1) chk("accept_req", o_mem_req, 1'b1);
            if (o_done) begin
                done_seen = 1'b1;
                chk("done_cycle", cyc, exp_done);
                chk("done_busy", o_busy, 1'b1);
                chk("done_req", o_mem_req, 1'b0);
                chk("sb_drained", req_q.size(), 0);
                chk("line_pending", line_q.size(), 1);
                if (line_q.size() > 0) chk("line", o_line, line_q.pop_front());
                if (miss_at_done) begin
                    i_miss      = 1'b1;
                    i_miss_addr = 32'h0000_7700;
                end
            end else begin
                chk("busy", o_busy, 1'b1);
                if (have_prev) begin
                    chk("hold_req", o_mem_req, 1'b1);
                    chk("hold_we", o_mem_we, prev_we);
                    chk("hold_addr", o_mem_addr, prev_addr);
                    chk("hold_wdata", o_mem_wdata, prev_wdata);
                end
                have_prev = 1'b0;
                if (o_mem_req) begin
                    phase++;
                    if (phase >= period) begin
                        phase     = 0;
                        i_mem_ack = 1'b1;
                        if (req_q.size() == 0) begin
                            chk("extra_req", o_mem_req, 1'b0);
                        end else begin
                            e = req_q.pop_front();
                            chk("req_we", o_mem_we, e.we);
                            chk("req_addr", o_mem_addr, e.addr);
                            if (e.we || !WB) chk("req_wdata", o_mem_wdata, e.we ? e.data : 32'h0);
                            if (!e.we) i_mem_rdata = e.data;
                        end
                    end else begin
                        have_prev  = 1'b1;
                        prev_we    = o_mem_we;
                        prev_addr  = o_mem_addr;
                        prev_wdata = o_mem_wdata;
                    end
                end
            end
        end
        chk("done_seen", done_seen, 1'b1);
        if (!done_seen) begin
            req_q.delete();
            line_q.delete();
        end
        if (miss_at_done) begin
            @(negedge clk);
            i_miss = 1'b0;
            chk("done_miss_busy", o_busy, 1'b0);
            chk("done_miss_req", o_mem_req, 1'b0);
        end
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        last_line     = '0;
        rst           = 1'b1;
        i_miss        = 1'b0;
        i_miss_addr   = '0;
        i_evict_valid = 1'b0;
        i_evict_addr  = '0;
        i_evict_data  = '0;
        i_mem_ack     = 1'b0;
        i_mem_rdata   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_done", o_done, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_req", o_mem_req, 1'b0);
        chk("rst_we", o_mem_we, 1'b0);
        chk("rst_addr", o_mem_addr, 32'h0);
        chk("rst_wdata", o_mem_wdata, 32'h0);
        chk("rst_line", o_line, '0);
        rst = 1'b0;

        // Stray ack while idle must not touch the line.
        @(negedge clk);
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        i_mem_ack   = 1'b0;
        chk("idle_ack_line", o_line, last_line);
        chk("idle_ack_req", o_mem_req, 1'b0);

        start_miss(32'h0000_1234, 1'b0, 32'h0, 32'h0, 32'hA000_0000);
        service(1, 0, 1'b1);

        start_miss(32'h0000_1200, 1'b1, 32'h0000_8040, 32'h0000_00D0, 32'hB000_0000);
        service(1, 0, 1'b0);

        start_miss(32'h0000_3000, 1'b0, 32'h0, 32'h0, 32'h5000_0000);
        service(3, 10, 1'b0);

        start_miss(32'h0000_0ABC, 1'b1, 32'h0000_9FC0, 32'h7700_0000, 32'h6000_0000);
        service(2, 5, 1'b0);

        // Reset in the middle of a fill once five words have landed.
        start_miss(32'h0000_2040, 1'b0, 32'h0, 32'h0, 32'hC000_0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            i_miss      = 1'b0;
            i_mem_ack   = 1'b1;
            i_mem_rdata = 32'hC000_0000 + 32'(k);
        end
        @(negedge clk);
        i_mem_ack = 1'b0;
        chk("pre_rst_addr", o_mem_addr, 32'h0000_2054);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_req", o_mem_req, 1'b0);
        chk("midrst_busy", o_busy, 1'b0);
        chk("midrst_line", o_line, '0);
        chk("midrst_addr", o_mem_addr, 32'h0);
        chk("midrst_done", o_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req_q.delete();
        line_q.delete();
        last_line = '0;

        start_miss(32'h0000_2040, 1'b1, 32'h0000_4000, 32'h1111_0000, 32'hE000_0000);
        service(1, 0, 1'b0);

        @(negedge clk);
        chk("final_line_hold", o_line, last_line);
        chk("final_busy", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
